id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline stage directly downstream of the register file. Captures DAT1/DAT2
//  read operands plus decoded fields into EX-side registers. Detects load-use hazards,
//  inserts bubbles, holds on downstream backpressure and squashes on branch flush.
//  Drives id_stall back to the PC/IF-ID registers.
// PARAMETERS
//  XLEN    32  operand, PC and immediate width
//  CTRL_W  12  width of opaque decoded control bundle (ALU op, mem_wr, reg_wr, ...)
// PORTS
//  clk         in   1       clock; all EX-side registers update on posedge
//  rst         in   1       asynchronous, active-high reset
//  id_valid    in   1       decode slot holds a real instruction
//  id_pc       in   XLEN    PC of decode instruction
//  id_rs1      in   5       source reg 1 (same index driven to rd_reg1)
//  id_rs2      in   5       source reg 2 (same index driven to rd_reg2)
//  id_rd       in   5       destination reg
//  id_use_rs1  in   1       instruction reads rs1
//  id_use_rs2  in   1       instruction reads rs2
//  id_is_load  in   1       instruction is a load
//  id_dat1     in   XLEN    register-file DAT1
//  id_dat2     in   XLEN    register-file DAT2
//  id_imm      in   XLEN    sign-extended immediate
//  id_ctrl     in   CTRL_W  decoded control bundle
//  ex_ready    in   1       EX accepts the held instruction this cycle
//  flush       in   1       branch/jump taken: squash ID and EX contents
//  id_stall    out  1       combinational: hold PC and IF/ID this cycle
//  ex_valid    out  1       EX register holds a real instruction
//  ex_pc, ex_rs1, ex_rs2, ex_rd, ex_is_load, ex_dat1, ex_dat2, ex_imm, ex_ctrl
//              out  (widths as ID)  registered copies of ID fields
//  perf_stall, perf_bubble, perf_flush  out 32  event counters (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: every ex_* output, ex_valid and all counters = 0; state = RUN.
//  - hazard = id_valid & ex_valid & ex_is_load & (ex_rd!=0) &
//      ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
//  - Priority per posedge: flush > !ex_ready > hazard > advance.
//  - flush: ex_valid<=0 (other ex_* don't-care, hold); id_stall=0; state->RUN.
//  - !ex_ready (no flush): all ex_* hold; id_stall=1.
//  - hazard & ex_ready: ex_valid<=0 (bubble), data fields hold; id_stall=1;
//    state RUN->BUBBLE. Next cycle load has left EX, hazard clears; BUBBLE->RUN.
//  - advance: ex_* <= id_*, ex_valid<=id_valid; id_stall=0. Latency ID->EX 1 cycle.
//  - id_stall is purely combinational from current inputs and EX registers.
//  - id_valid=0 never stalls; rd==x0 never causes hazard.
//  - Reg file writes on negedge, so id_dat1/2 already reflect same-cycle WB; no bypass here.
//  - rst mid-stall: outputs and state return to reset values immediately, asynchronously.
//  - BUBBLE state asserting hazard again (ex_valid=0) is impossible; treat as RUN.
// CONFIGURATION
//  ID_EX_PERF_EN defined: perf_stall +1 each cycle id_stall=1; perf_bubble +1 per
//   inserted bubble; perf_flush +1 per cycle flush=1; all saturate at 32'hFFFFFFFF.
//  ID_EX_PERF_EN undefined: counters not built; perf_* ports tied to 32'h0.
// TESTING
//  1. Reset: rst=1 mid-run -> ex_valid=0, ex_dat1=0, id_stall=0, counters=0 at once.
//  2. Stream: 3 valid instrs, ex_ready=1 -> each appears on ex_* exactly 1 cycle later.
//  3. Load-use: EX lw x5; ID add x6,x5,x1 -> id_stall=1 one cycle, one bubble, add enters next.
//  4. No false hazard: EX lw x0; ID reads x0 -> id_stall=0; ID uses_rs2=0, rs2=x5 -> no stall.
//  5. Backpressure: ex_ready=0 for 3 cycles -> ex_* stable, id_stall=1 x3, then advance.
//  6. Flush during hazard/backpressure -> ex_valid=0 next cycle, id_stall=0; with
//     ID_EX_PERF_EN, perf_flush=1, perf_bubble unchanged.

Source files
------------

// File: rtl/id_ex_if.sv
// ID/EX stage bus: decode-side fields in, EX-side registered copies and
// stall/perf feedback out. The master drives the decode slot; the slave is the stage.
interface id_ex_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CTRL_W = 12
);
  logic              id_valid;
  logic [XLEN-1:0]   id_pc;
  logic [4:0]        id_rs1;
  logic [4:0]        id_rs2;
  logic [4:0]        id_rd;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic              id_is_load;
  logic [XLEN-1:0]   id_dat1;
  logic [XLEN-1:0]   id_dat2;
  logic [XLEN-1:0]   id_imm;
  logic [CTRL_W-1:0] id_ctrl;
  logic              ex_ready;
  logic              flush;

  logic              id_stall;
  logic              ex_valid;
  logic [XLEN-1:0]   ex_pc;
  logic [4:0]        ex_rs1;
  logic [4:0]        ex_rs2;
  logic [4:0]        ex_rd;
  logic              ex_is_load;
  logic [XLEN-1:0]   ex_dat1;
  logic [XLEN-1:0]   ex_dat2;
  logic [XLEN-1:0]   ex_imm;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [31:0]       perf_stall;
  logic [31:0]       perf_bubble;
  logic [31:0]       perf_flush;

  modport master (
    output id_valid, id_pc, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
           id_is_load, id_dat1, id_dat2, id_imm, id_ctrl, ex_ready, flush,
    input  id_stall, ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_is_load,
           ex_dat1, ex_dat2, ex_imm, ex_ctrl, perf_stall, perf_bubble, perf_flush
  );

  modport slave (
    input  id_valid, id_pc, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
           id_is_load, id_dat1, id_dat2, id_imm, id_ctrl, ex_ready, flush,
    output id_stall, ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_is_load,
           ex_dat1, ex_dat2, ex_imm, ex_ctrl, perf_stall, perf_bubble, perf_flush
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, backpressure hold
// and branch flush. Optional event counters are built when ID_EX_PERF_EN is defined;
// otherwise the perf_* outputs read as zero.
module id_ex_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CTRL_W = 12
) (
  input  logic     clk,
  input  logic     rst,
  id_ex_if.slave   bus
);

  typedef enum logic {
    S_RUN    = 1'b0,
    S_BUBBLE = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_next_state;

  logic              r_ex_valid;
  logic [XLEN-1:0]   r_ex_pc;
  logic [4:0]        r_ex_rs1;
  logic [4:0]        r_ex_rs2;
  logic [4:0]        r_ex_rd;
  logic              r_ex_is_load;
  logic [XLEN-1:0]   r_ex_dat1;
  logic [XLEN-1:0]   r_ex_dat2;
  logic [XLEN-1:0]   r_ex_imm;
  logic [CTRL_W-1:0] r_ex_ctrl;

  logic              w_hazard;
  logic              w_kill;
  logic              w_bubble;
  logic              w_advance;
  logic              w_stall;
  logic              w_id_stall;

  // Load-use hazard: the load in EX writes a register the decode instruction reads.
  always_comb begin
    w_hazard = bus.id_valid & r_ex_valid & r_ex_is_load & (r_ex_rd != 5'd0) &
               ((bus.id_use_rs1 & (bus.id_rs1 == r_ex_rd)) |
                (bus.id_use_rs2 & (bus.id_rs2 == r_ex_rd)));
  end

  // Per-cycle action select: flush > backpressure > hazard > advance.
  // In BUBBLE the hazard cannot re-assert (ex_valid is 0), so both states share the rules.
  always_comb begin
    w_next_state = r_state;
    w_kill       = 1'b0;
    w_bubble     = 1'b0;
    w_advance    = 1'b0;
    w_stall      = 1'b0;
    if (bus.flush) begin
      w_kill       = 1'b1;
      w_next_state = S_RUN;
    end else if (!bus.ex_ready) begin
      w_stall      = 1'b1;
    end else if (w_hazard) begin
      w_stall      = 1'b1;
      w_bubble     = 1'b1;
      w_next_state = S_BUBBLE;
    end else begin
      w_advance    = 1'b1;
      w_next_state = S_RUN;
    end
  end

  // Stall is masked while reset is held so the front end is released immediately.
  always_comb begin
    w_id_stall = w_stall & ~rst;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_RUN;
    else     r_state <= w_next_state;
  end

  // EX-side registers: kill/bubble clear only the valid bit, data fields hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_valid   <= 1'b0;
      r_ex_pc      <= '0;
      r_ex_rs1     <= '0;
      r_ex_rs2     <= '0;
      r_ex_rd      <= '0;
      r_ex_is_load <= 1'b0;
      r_ex_dat1    <= '0;
      r_ex_dat2    <= '0;
      r_ex_imm     <= '0;
      r_ex_ctrl    <= '0;
    end else if (w_kill || w_bubble) begin
      r_ex_valid   <= 1'b0;
    end else if (w_advance) begin
      r_ex_valid   <= bus.id_valid;
      r_ex_pc      <= bus.id_pc;
      r_ex_rs1     <= bus.id_rs1;
      r_ex_rs2     <= bus.id_rs2;
      r_ex_rd      <= bus.id_rd;
      r_ex_is_load <= bus.id_is_load;
      r_ex_dat1    <= bus.id_dat1;
      r_ex_dat2    <= bus.id_dat2;
      r_ex_imm     <= bus.id_imm;
      r_ex_ctrl    <= bus.id_ctrl;
    end
  end

  assign bus.id_stall   = w_id_stall;
  assign bus.ex_valid   = r_ex_valid;
  assign bus.ex_pc      = r_ex_pc;
  assign bus.ex_rs1     = r_ex_rs1;
  assign bus.ex_rs2     = r_ex_rs2;
  assign bus.ex_rd      = r_ex_rd;
  assign bus.ex_is_load = r_ex_is_load;
  assign bus.ex_dat1    = r_ex_dat1;
  assign bus.ex_dat2    = r_ex_dat2;
  assign bus.ex_imm     = r_ex_imm;
  assign bus.ex_ctrl    = r_ex_ctrl;

`ifdef ID_EX_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_bubble;
  logic [31:0] r_perf_flush;

  // Saturating event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_stall  <= '0;
      r_perf_bubble <= '0;
      r_perf_flush  <= '0;
    end else begin
      if (w_id_stall && (r_perf_stall != '1))  r_perf_stall  <= r_perf_stall + 32'd1;
      if (w_bubble   && (r_perf_bubble != '1)) r_perf_bubble <= r_perf_bubble + 32'd1;
      if (bus.flush  && (r_perf_flush != '1))  r_perf_flush  <= r_perf_flush + 32'd1;
    end
  end

  assign bus.perf_stall  = r_perf_stall;
  assign bus.perf_bubble = r_perf_bubble;
  assign bus.perf_flush  = r_perf_flush;
`else
  assign bus.perf_stall  = '0;
  assign bus.perf_bubble = '0;
  assign bus.perf_flush  = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios followed by random
// traffic, all compared against a rule-level model of the EX slot.
module tb_id_ex_stage;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned CTRL_W = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;

  id_ex_if #(.XLEN(XLEN), .CTRL_W(CTRL_W)) bus ();

  id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit               valid;
    logic [XLEN-1:0]  pc;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    bit               ld;
    logic [XLEN-1:0]  d1;
    logic [XLEN-1:0]  d2;
    logic [XLEN-1:0]  imm;
    logic [CTRL_W-1:0] ctrl;
  } ex_t;

  ex_t         m;
  logic [31:0] m_ps, m_pb, m_pf;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [31:0] pb_before, pf_before;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] perf_exp(input logic [31:0] v);
`ifdef ID_EX_PERF_EN
    return v;
`else
    return (v & 32'h0);
`endif
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic bit model_hazard();
    return bus.id_valid && m.valid && m.ld && (m.rd != 5'd0) &&
           ((bus.id_use_rs1 && (bus.id_rs1 == m.rd)) ||
            (bus.id_use_rs2 && (bus.id_rs2 == m.rd)));
  endfunction

  function automatic bit model_stall();
    return !rst && !bus.flush && (!bus.ex_ready || model_hazard());
  endfunction

  task automatic model_reset();
    m    = '{default: '0};
    m_ps = '0;
    m_pb = '0;
    m_pf = '0;
  endtask

  task automatic model_clock();
    bit st;
    bit hz;
    st = model_stall();
    hz = model_hazard();
    if (bus.flush) begin
      m.valid = 1'b0;
      m_pf    = sat_inc(m_pf);
    end else if (!bus.ex_ready) begin
      // slot holds
    end else if (hz) begin
      m.valid = 1'b0;
      m_pb    = sat_inc(m_pb);
    end else begin
      m.valid = bus.id_valid;
      m.pc    = bus.id_pc;
      m.rs1   = bus.id_rs1;
      m.rs2   = bus.id_rs2;
      m.rd    = bus.id_rd;
      m.ld    = bus.id_is_load;
      m.d1    = bus.id_dat1;
      m.d2    = bus.id_dat2;
      m.imm   = bus.id_imm;
      m.ctrl  = bus.id_ctrl;
    end
    if (st) m_ps = sat_inc(m_ps);
  endtask

  task automatic check_outputs();
    check_eq("ex_valid",    bus.ex_valid,    m.valid);
    check_eq("ex_pc",       bus.ex_pc,       m.pc);
    check_eq("ex_rs1",      bus.ex_rs1,      m.rs1);
    check_eq("ex_rs2",      bus.ex_rs2,      m.rs2);
    check_eq("ex_rd",       bus.ex_rd,       m.rd);
    check_eq("ex_is_load",  bus.ex_is_load,  m.ld);
    check_eq("ex_dat1",     bus.ex_dat1,     m.d1);
    check_eq("ex_dat2",     bus.ex_dat2,     m.d2);
    check_eq("ex_imm",      bus.ex_imm,      m.imm);
    check_eq("ex_ctrl",     bus.ex_ctrl,     m.ctrl);
    check_eq("perf_stall",  bus.perf_stall,  perf_exp(m_ps));
    check_eq("perf_bubble", bus.perf_bubble, perf_exp(m_pb));
    check_eq("perf_flush",  bus.perf_flush,  perf_exp(m_pf));
  endtask

  // Inputs are applied just after a negedge; want_stall < 0 means no directed stall value.
  task automatic do_cycle(input int want_stall);
    #1;
    check_eq("id_stall", bus.id_stall, model_stall());
    if (want_stall >= 0) check_eq("dir_stall", bus.id_stall, want_stall[0]);
    @(posedge clk);
    model_clock();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic set_id(input bit v, input logic [31:0] pc, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd, input bit u1,
                        input bit u2, input bit ld);
    bus.id_valid   = v;
    bus.id_pc      = pc;
    bus.id_rs1     = rs1;
    bus.id_rs2     = rs2;
    bus.id_rd      = rd;
    bus.id_use_rs1 = u1;
    bus.id_use_rs2 = u2;
    bus.id_is_load = ld;
    bus.id_dat1    = $urandom;
    bus.id_dat2    = $urandom;
    bus.id_imm     = $urandom;
    bus.id_ctrl    = CTRL_W'($urandom);
  endtask

  task automatic rand_inputs();
    logic [4:0] regs [4];
    regs[0] = 5'd0; regs[1] = 5'd5; regs[2] = 5'd6; regs[3] = 5'd7;
    set_id(($urandom_range(0, 9) < 8), $urandom,
           regs[$urandom_range(0, 3)], regs[$urandom_range(0, 3)],
           regs[$urandom_range(0, 3)], $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    bus.ex_ready = ($urandom_range(0, 3) != 0);
    bus.flush    = ($urandom_range(0, 9) == 0);
  endtask

  task automatic async_reset_check();
    rst = 1'b1;
    bus.ex_ready = 1'b0;
    #1;
    check_eq("rst_ex_valid",  bus.ex_valid,    1'b0);
    check_eq("rst_ex_dat1",   bus.ex_dat1,     32'h0);
    check_eq("rst_id_stall",  bus.id_stall,    1'b0);
    check_eq("rst_perf_st",   bus.perf_stall,  32'h0);
    check_eq("rst_perf_bb",   bus.perf_bubble, 32'h0);
    check_eq("rst_perf_fl",   bus.perf_flush,  32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.ex_ready = 1'b1;
    bus.flush = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    set_id(0, '0, '0, '0, '0, 0, 0, 0);
    bus.ex_ready = 1'b1;
    bus.flush    = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset_valid", bus.ex_valid, 1'b0);
    check_eq("reset_stall", bus.id_stall, 1'b0);
    check_outputs();
    rst = 1'b0;

    // Stream of three instructions, one cycle ID->EX latency
    for (int i = 0; i < 3; i++) begin
      set_id(1, 32'h100 + 32'(4 * i), 5'd1, 5'd2, 5'(10 + i), 1, 1, 0);
      do_cycle(0);
      check_eq("stream_pc", bus.ex_pc, 32'h100 + 32'(4 * i));
      check_eq("stream_rd", bus.ex_rd, 5'(10 + i));
    end

    // Load-use: lw x5 then add x6,x5,x1
    set_id(1, 32'h200, 5'd1, 5'd0, 5'd5, 1, 0, 1);
    do_cycle(0);
    set_id(1, 32'h204, 5'd5, 5'd1, 5'd6, 1, 1, 0);
    do_cycle(1);
    check_eq("lu_bubble", bus.ex_valid, 1'b0);
    do_cycle(0);
    check_eq("lu_add_rd", bus.ex_rd, 5'd6);
    check_eq("lu_add_v",  bus.ex_valid, 1'b1);

    // No false hazards: x0 destination, unused rs2
    set_id(1, 32'h300, 5'd1, 5'd0, 5'd0, 1, 0, 1);
    do_cycle(0);
    set_id(1, 32'h304, 5'd0, 5'd0, 5'd7, 1, 1, 0);
    do_cycle(0);
    set_id(1, 32'h308, 5'd1, 5'd0, 5'd5, 1, 0, 1);
    do_cycle(0);
    set_id(1, 32'h30C, 5'd1, 5'd5, 5'd8, 1, 0, 0);
    do_cycle(0);

    // Backpressure for three cycles, then advance
    set_id(1, 32'h400, 5'd2, 5'd3, 5'd9, 1, 1, 0);
    bus.ex_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      do_cycle(1);
      check_eq("bp_hold_pc", bus.ex_pc, 32'h30C);
    end
    bus.ex_ready = 1'b1;
    do_cycle(0);
    check_eq("bp_adv_pc", bus.ex_pc, 32'h400);

    // Flush during a load-use hazard
    set_id(1, 32'h500, 5'd1, 5'd0, 5'd5, 1, 0, 1);
    do_cycle(0);
    pb_before = bus.perf_bubble;
    pf_before = bus.perf_flush;
    set_id(1, 32'h504, 5'd5, 5'd0, 5'd6, 1, 0, 0);
    bus.flush = 1'b1;
    do_cycle(0);
    check_eq("fl_valid",  bus.ex_valid,    1'b0);
    check_eq("fl_bubble", bus.perf_bubble, pb_before);
    check_eq("fl_count",  bus.perf_flush,  perf_exp(pf_before + 32'd1));

    // Flush during backpressure
    set_id(1, 32'h600, 5'd1, 5'd2, 5'd3, 1, 1, 0);
    bus.flush = 1'b0;
    do_cycle(0);
    bus.ex_ready = 1'b0;
    bus.flush    = 1'b1;
    do_cycle(0);
    check_eq("flbp_valid", bus.ex_valid, 1'b0);
    bus.ex_ready = 1'b1;
    bus.flush    = 1'b0;

    // Random traffic with an asynchronous reset in the middle
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        set_id(1, 32'h700, 5'd1, 5'd2, 5'd3, 1, 1, 0);
        bus.ex_ready = 1'b1;
        bus.flush    = 1'b0;
        do_cycle(0);
        async_reset_check();
      end
      rand_inputs();
      do_cycle(-1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
